// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read arbiter and the future write arbiter.
package axi_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_pl_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser
// whenever a grant is taken.
module rr_arb2 #(
  parameter int FIRST_PRI = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req[0] && req[1]) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    if (en && |req) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'(FIRST_PRI);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter with a single outstanding burst;
// the granted master index is carried in the slave-side ID MSB.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ID_MAS    = 4,
  parameter int FIRST_PRI = 0
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_MAS-1:0] m0_arid,
  input  logic [31:0]       m0_araddr,
  input  logic [3:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_MAS-1:0] m0_rid,
  output logic [31:0]       m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ID_MAS-1:0] m1_arid,
  input  logic [31:0]       m1_araddr,
  input  logic [3:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_MAS-1:0] m1_rid,
  output logic [31:0]       m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ID_MAS:0]   s_arid,
  output logic [31:0]       s_araddr,
  output logic [3:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [ID_MAS:0]   s_rid,
  input  logic [31:0]       s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready
);

  arb_state_e        state_q, state_d;
  logic              gidx_q, gidx_d;
  logic [ID_MAS-1:0] arid_q, arid_d;
  ar_pl_t            ar_q, ar_d;
  logic [3:0]        beat_q, beat_d;
  logic              err_q, err_d;

  logic [1:0] gnt;
  logic       arb_en;
  logic       id_ok;
  logic       g_rready;
  logic       r_take;
  ar_pl_t     m0_pl, m1_pl;

  rr_arb2 #(
    .FIRST_PRI(FIRST_PRI)
  ) u_arb (
    .clk(aclk),
    .rst(areset),
    .req({m1_arvalid, m0_arvalid}),
    .en (arb_en),
    .gnt(gnt)
  );

  assign m0_pl = '{m0_araddr, m0_arlen,
                   m0_arsize, m0_arburst};
  assign m1_pl = '{m1_araddr, m1_arlen,
                   m1_arsize, m1_arburst};

  // Beats tagged for the other master are swallowed, not forwarded.
  assign id_ok    = (s_rid[ID_MAS] == gidx_q);
  assign g_rready = gidx_q ? m1_rready : m0_rready;
  assign r_take   = id_ok ? g_rready : 1'b1;

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    arid_d     = arid_q;
    ar_d       = ar_q;
    beat_d     = beat_q;
    err_d      = err_q;
    arb_en     = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        beat_d     = 4'd0;
        arb_en     = 1'b1;
        m0_arready = gnt[0] & ~areset;
        m1_arready = gnt[1] & ~areset;
        if (|gnt) begin
          gidx_d  = gnt[1];
          arid_d  = gnt[1] ? m1_arid : m0_arid;
          ar_d    = gnt[1] ? m1_pl : m0_pl;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_rready = r_take;
        if (id_ok && s_rvalid) begin
          m0_rvalid = ~gidx_q;
          m1_rvalid = gidx_q;
        end
        if (s_rvalid && r_take) begin
          beat_d = beat_q + 4'd1;
          if (!id_ok) err_d = 1'b1;
          // Final expected beat must carry rlast.
          if (beat_q == ar_q.len && !s_rlast)
            err_d = 1'b1;
          if (s_rlast) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      gidx_q  <= 1'b0;
      arid_q  <= '0;
      ar_q    <= '0;
      beat_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      arid_q  <= arid_d;
      ar_q    <= ar_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign s_arid    = {gidx_q, arid_q};
  assign s_araddr  = ar_q.addr;
  assign s_arlen   = ar_q.len;
  assign s_arsize  = ar_q.size;
  assign s_arburst = ar_q.burst;

  assign m0_rid   = s_rid[ID_MAS-1:0];
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rid   = s_rid[ID_MAS-1:0];
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with hand-computed expectations.
module tb_axi_read_arbiter;
  import axi_pkg::*;

  logic        aclk, areset;
  logic [3:0]  m0_arid, m1_arid;
  logic [31:0] m0_araddr, m1_araddr;
  logic [3:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        m0_arvalid, m1_arvalid;
  logic        m0_arready, m1_arready;
  logic [3:0]  m0_rid, m1_rid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rready, m1_rready;
  logic [4:0]  s_arid, s_rid;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_arvalid, s_arready;
  logic        s_rlast, s_rvalid, s_rready;

  int n_chk = 0;
  int n_fail = 0;

  axi_read_arbiter #(.ID_MAS(4), .FIRST_PRI(0)) dut (
    .aclk(aclk), .areset(areset),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rid(m0_rid),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rid(m1_rid),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic ar_phase(input int g,
                          input logic [4:0] eid,
                          input logic [31:0] eaddr,
                          input logic [3:0] elen);
    #1;
    chk("arready_gnt", g ? m1_arready : m0_arready, 1);
    chk("arready_lose", g ? m0_arready : m1_arready, 0);
    tick();
    if (g != 0) m1_arvalid = 1'b0;
    else        m0_arvalid = 1'b0;
    #1;
    chk("s_arvalid", s_arvalid, 1);
    chk("s_arid", s_arid, eid);
    chk("s_araddr", s_araddr, eaddr);
    chk("s_arlen", s_arlen, elen);
    chk("s_arsize", s_arsize, 3'd2);
    chk("s_arburst", s_arburst, 2'd1);
    chk("hold_m0_arready", m0_arready, 0);
    chk("hold_m1_arready", m1_arready, 0);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
  endtask

  task automatic r_phase(input int g,
                         input logic [3:0] id,
                         input int n);
    for (int i = 0; i < n; i++) begin
      s_rvalid  = 1'b1;
      s_rid     = {g[0], id};
      s_rdata   = 32'hD000_0000 + (g << 8) + i;
      s_rresp   = (i == 1) ? RESP_SLVERR : RESP_OKAY;
      s_rlast   = (i == n - 1);
      m0_rready = 1'b1;
      m1_rready = 1'b1;
      #1;
      chk("rvalid_gnt", g ? m1_rvalid : m0_rvalid, 1);
      chk("rvalid_lose", g ? m0_rvalid : m1_rvalid, 0);
      chk("rdata", g ? m1_rdata : m0_rdata,
          32'hD000_0000 + (g << 8) + i);
      chk("rresp", g ? m1_rresp : m0_rresp,
          (i == 1) ? 2'b10 : 2'b00);
      chk("rid", g ? m1_rid : m0_rid, id);
      chk("s_rready", s_rready, 1);
      tick();
    end
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
    #1;
    chk("idle_after", dut.state_q, ST_IDLE);
  endtask

  initial begin
    int b;
    logic hs;
    areset = 1'b1;
    m0_arid = '0; m1_arid = '0;
    m0_araddr = '0; m1_araddr = '0;
    m0_arlen = '0; m1_arlen = '0;
    m0_arsize = 3'd2; m1_arsize = 3'd2;
    m0_arburst = 2'd1; m1_arburst = 2'd1;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    m0_rready = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rid = '0;
    s_rdata = '0; s_rresp = '0;
    s_rlast = 1'b0; s_rvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_err", dut.err_q, 0);
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    areset = 1'b0;

    // both request at once after reset
    m0_arid = 4'h3; m0_araddr = 32'h2000;
    m0_arlen = 4'd1; m0_arvalid = 1'b1;
    m1_arid = 4'h0; m1_araddr = 32'h3000;
    m1_arlen = 4'd0; m1_arvalid = 1'b1;
    ar_phase(0, 5'h03, 32'h2000, 4'd1);
    r_phase(0, 4'h3, 2);
    m0_araddr = 32'h2100;
    m0_arvalid = 1'b1;
    ar_phase(1, 5'h10, 32'h3000, 4'd0);
    r_phase(1, 4'h0, 1);
    ar_phase(0, 5'h03, 32'h2100, 4'd1);
    r_phase(0, 4'h3, 2);

    // m0 alone, 4-beat burst
    m0_arid = 4'h0; m0_araddr = 32'h1000;
    m0_arlen = 4'd3; m0_arvalid = 1'b1;
    ar_phase(0, 5'h00, 32'h1000, 4'd3);
    r_phase(0, 4'h0, 4);

    // slave stalls address for five cycles
    m1_arid = 4'h2; m1_araddr = 32'h4000;
    m1_arlen = 4'd3; m1_arvalid = 1'b1;
    #1;
    chk("stall_m1_arready", m1_arready, 1);
    tick();
    m1_arvalid = 1'b0;
    s_rvalid = 1'b1;
    s_rid = 5'h12;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_s_arvalid", s_arvalid, 1);
      chk("stall_s_araddr", s_araddr, 32'h4000);
      chk("stall_s_arid", s_arid, 5'h12);
      chk("stall_m1_rvalid", m1_rvalid, 0);
      chk("stall_s_rready", s_rready, 0);
      tick();
    end
    s_rvalid = 1'b0;
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;

    // m1 rready toggles through the burst
    b = 0;
    for (int c = 0; c < 20 && b < 4; c++) begin
      s_rvalid = 1'b1;
      s_rid = 5'h12;
      s_rdata = 32'h4400 + b;
      s_rlast = (b == 3);
      m1_rready = (c % 2 == 0);
      #1;
      chk("tog_s_rready", s_rready, m1_rready);
      chk("tog_m1_rvalid", m1_rvalid, 1);
      chk("tog_m1_rdata", m1_rdata, 32'h4400 + b);
      hs = m1_rready;
      tick();
      if (hs) b++;
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    m1_rready = 1'b0;
    #1;
    chk("tog_beats", b, 4);
    chk("tog_idle", dut.state_q, ST_IDLE);
    chk("tog_no_err", dut.err_q, 0);

    // beat tagged for m1 while m0 owns the bus
    m0_arid = 4'h1; m0_araddr = 32'h5000;
    m0_arlen = 4'd1; m0_arvalid = 1'b1;
    ar_phase(0, 5'h01, 32'h5000, 4'd1);
    s_rvalid = 1'b1;
    s_rid = 5'h11;
    s_rlast = 1'b0;
    m0_rready = 1'b0;
    #1;
    chk("bad_m0_rvalid", m0_rvalid, 0);
    chk("bad_m1_rvalid", m1_rvalid, 0);
    chk("bad_s_rready", s_rready, 1);
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("bad_err", dut.err_q, 1);
    r_phase(0, 4'h1, 2);

    // reset during beat 2 of a burst
    m0_arid = 4'h4; m0_araddr = 32'h6000;
    m0_arlen = 4'd3; m0_arvalid = 1'b1;
    ar_phase(0, 5'h04, 32'h6000, 4'd3);
    for (int i = 0; i < 2; i++) begin
      s_rvalid = 1'b1;
      s_rid = 5'h04;
      m0_rready = 1'b1;
      tick();
    end
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    #1;
    chk("pre_rst_rvalid", m0_rvalid, 1);
    #2;
    areset = 1'b1;
    #1;
    chk("arst_m0_rvalid", m0_rvalid, 0);
    chk("arst_s_rready", s_rready, 0);
    chk("arst_s_arvalid", s_arvalid, 0);
    chk("arst_m0_arready", m0_arready, 0);
    chk("arst_m1_arready", m1_arready, 0);
    chk("arst_err", dut.err_q, 0);
    s_rvalid = 1'b0;
    m0_rready = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // FIRST_PRI wins again; arlen 1 burst missing rlast on beat 1
    m0_araddr = 32'h7000;
    m0_arlen = 4'd1;
    ar_phase(0, 5'h04, 32'h7000, 4'd1);
    m1_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 1'b1;
      s_rid = 5'h04;
      s_rlast = (i == 2);
      m0_rready = 1'b1;
      #1;
      chk("len_err_before", dut.err_q, (i == 2));
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    m0_rready = 1'b0;
    #1;
    chk("len_err_set", dut.err_q, 1);
    chk("len_idle", dut.state_q, ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Param ID_MAS, default 4, master-side ID width; slave-side ID width SHALL be ID_MAS+1.
REQ-002 Param FIRST_PRI, default 0, master index holding priority after reset.
REQ-003 aclk  in  1  single clock, all state updates on rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 m{0,1}_arid/araddr/arlen/arsize/arburst  in  ID_MAS/32/4/3/2  AR payload from master i.
REQ-006 m{0,1}_arvalid  in  1 / m{0,1}_arready  out  1  AR handshake, master i.
REQ-007 m{0,1}_rid/rdata/rresp/rlast  out  ID_MAS/32/2/1  R payload to master i.
REQ-008 m{0,1}_rvalid  out  1 / m{0,1}_rready  in  1  R handshake, master i.
REQ-009 s_arid  out  ID_MAS+1; s_araddr/arlen/arsize/arburst  out  32/4/3/2; s_arvalid  out  1; s_arready  in  1.
REQ-010 s_rid  in  ID_MAS+1; s_rdata/rresp/rlast  in  32/2/1; s_rvalid  in  1; s_rready  out  1.

Function
REQ-011 FSM states IDLE, ADDR, DATA; exactly one read burst in flight.
REQ-012 IDLE: any m_i_arvalid -> grant chosen, payload registered, -> ADDR next cycle; none -> stay IDLE.
REQ-013 Arbitration round-robin: both valid -> grant to pointer master; only one valid -> that master.
REQ-014 Pointer SHALL move to the non-granted master on each grant.
REQ-015 m_i_arready SHALL be 1 only in IDLE for the granted master, same cycle grant is taken (comb); loser sees arready 0.
REQ-016 ADDR: s_arvalid=1, payload stable from register; s_arid = {grant_idx, m_arid}; s_arvalid & s_arready -> DATA.
REQ-017 DATA: s_rready = m_g_rready (comb); m_g_rvalid = s_rvalid; non-granted m_rvalid=0; m_g_rid = s_rid[ID_MAS-1:0].
REQ-018 R routing SHALL use s_rid[ID_MAS]; mismatch with grant -> beat dropped (s_rready=1, no m_rvalid), sticky flag err_q set (internal, observable in sim).
REQ-019 DATA exit on s_rvalid & s_rready & s_rlast -> IDLE; rresp passed through unmodified, error response does not abort.
REQ-020 New arvalid during ADDR/DATA SHALL be held off (arready 0) until return to IDLE; zero-bubble re-grant not required.
REQ-021 Beat counter (4 bit) increments per R handshake, clears in IDLE; counter == registered arlen without rlast SHALL set err_q; rlast still terminates.
REQ-022 Idle outputs: s_arvalid=0, s_rready=0, all m_rvalid=0, all m_arready=0 except REQ-015.

Reset
REQ-023 areset asserted at any time -> state IDLE, pointer FIRST_PRI, registered payload 0, beat counter 0, err_q 0, all valid/ready outputs 0 in same cycle (async).
REQ-024 Reset mid-burst abandons transaction; no slave draining performed.
REQ-025 First grant possible on first rising edge after areset deasserts.

Structure
REQ-026 State enum, RESP codes, width constants SHALL live in shared package axi_pkg, reused by master and future write arbiter.
REQ-027 Sub-module rr_arb2 (2-way round-robin, req[1:0] -> gnt one-hot, pointer update on enable).
REQ-028 No FIFOs; payload register is single entry.

Verification
REQ-029 m0 only, araddr 0x1000, arlen 3 -> s_arid 0x00, 4 beats to m0, m1_rvalid 0 throughout, IDLE after rlast.
REQ-030 m0 and m1 valid same cycle after reset -> m0 granted first, then m1 (s_arid 0x10), then m0 again if still requesting.
REQ-031 s_arready held 0 five cycles -> s_arvalid and payload stable all five, no R forwarded.
REQ-032 m1 rready toggling 1/0 during 4-beat burst -> s_rready mirrors, no beat lost or duplicated.
REQ-033 s_rid MSB = 1 while m0 granted -> beat dropped, err_q=1, m0_rvalid 0.
REQ-034 areset pulse during DATA beat 2 -> all outputs 0 immediately, next request granted to FIRST_PRI master.
